// File: rtl/rs485_pkg.sv
// Shared types and helpers for the RS-485 frame transmitter.
// Parity modes, controller states and per-character bit count.
package rs485_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  typedef enum logic [2:0] {
    IDLE,
    DIR_ON,
    FETCH,
    WAIT_DATA,
    SHIFT,
    DIR_OFF,
    HOLD
  } state_e;

  // Start bit + data + optional parity + stop bits.
  function automatic int frame_bits(input int data_bits, input int parity, input int stop_bits);
    return 1 + data_bits + ((parity != PAR_NONE) ? 1 : 0) + stop_bits;
  endfunction

endpackage

// File: rtl/rs485_frame_tx_shifter.sv
// Character serialiser: builds start/data/parity/stop on load and shifts it out LSB first,
// holding each bit CLKS_PER_BIT clocks. done is high during the final clock of the last stop bit.
module uart_tx_shifter
  import rs485_pkg::*;
#(
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int CLKS_PER_BIT = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load,
  input  logic [DATA_BITS-1:0] data,
  output logic                 tx,
  output logic                 done
);

  localparam int NB     = frame_bits(DATA_BITS, PARITY, STOP_BITS);
  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  logic [NB-1:0]     shreg_q, shreg_d, frame;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [3:0]        bit_q, bit_d;
  logic              active_q, active_d;
  logic              par_bit;
  logic              bit_end;

  assign par_bit = (PARITY == PAR_ODD) ? ~(^data) : (^data);

  always_comb begin
    frame = '1;
    frame[0] = 1'b0;
    frame[DATA_BITS:1] = data;
    if (PARITY != PAR_NONE) frame[DATA_BITS+1] = par_bit;
  end

  assign bit_end = active_q && (baud_q == BAUD_W'(CLKS_PER_BIT - 1));
  assign done    = bit_end && (bit_q == 4'(NB - 1));
  assign tx      = shreg_q[0];

  // Ones shift in from the top so the line settles idle-high after the last stop bit.
  always_comb begin
    shreg_d  = shreg_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    active_d = active_q;
    if (load) begin
      shreg_d  = frame;
      baud_d   = '0;
      bit_d    = '0;
      active_d = 1'b1;
    end else if (active_q) begin
      if (bit_end) begin
        baud_d  = '0;
        shreg_d = {1'b1, shreg_q[NB-1:1]};
        bit_d   = bit_q + 4'd1;
        if (done) active_d = 1'b0;
      end else begin
        baud_d = baud_q + BAUD_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shreg_q  <= '1;
      baud_q   <= '0;
      bit_q    <= '0;
      active_q <= 1'b0;
    end else begin
      shreg_q  <= shreg_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      active_q <= active_d;
    end
  end

endmodule

// File: rtl/rs485_frame_tx.sv
// RS-485 frame transmitter: request handshake, direction-pin sequencing,
// memory fetch of NBYTES characters and hand-off to the character shifter.
module rs485_frame_tx
  import rs485_pkg::*;
#(
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int CLKS_PER_BIT = 1,
  parameter int NBYTES       = 4,
  parameter int CYC_W        = 6,
  parameter int ADDR_W       = 9,
  parameter int RD_LAT       = 1,
  parameter int RX_TX_DLY    = 15,
  parameter int LEAD_DLY     = 30,
  parameter int TAIL_DLY     = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rq,
  input  logic [CYC_W-1:0]     cycle,
  input  logic [DATA_BITS-1:0] rd_data,
  output logic [ADDR_W-1:0]    rd_addr,
  output logic                 rd_en,
  output logic [7:0]           byte_idx,
  output logic                 busy,
  output logic                 full,
  output logic                 tx,
  output logic                 dir_tx,
  output logic                 dir_rx
);

  state_e            state_q, state_d;
  logic              rq_meta_q, rq_s_q;
  logic [15:0]       cnt_q, cnt_d;
  logic [1:0]        wait_q, wait_d;
  logic [7:0]        byte_idx_q, byte_idx_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic              rd_en_q, rd_en_d;
  logic              busy_q, busy_d;
  logic              full_q, full_d;
  logic              dir_tx_q, dir_tx_d;
  logic              dir_rx_q, dir_rx_d;
  logic              load;
  logic              sh_done;
  logic              last_byte;

  assign last_byte = ({1'b0, byte_idx_q} + 9'd1) == 9'(NBYTES);

  // Delay counts are compared one early so each output changes on the edge the count reaches its target.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q + 16'd1;
    wait_d     = wait_q;
    byte_idx_d = byte_idx_q;
    rd_addr_d  = rd_addr_q;
    rd_en_d    = 1'b0;
    busy_d     = busy_q;
    full_d     = full_q;
    dir_tx_d   = dir_tx_q;
    dir_rx_d   = dir_rx_q;
    load       = 1'b0;
    case (state_q)
      IDLE: begin
        full_d = 1'b0;
        if (rq_s_q) begin
          state_d  = DIR_ON;
          cnt_d    = '0;
          dir_rx_d = 1'b1;
          busy_d   = 1'b1;
        end
      end
      DIR_ON: begin
        if (cnt_q == 16'(RX_TX_DLY - 1)) dir_tx_d = 1'b1;
        if (cnt_q == 16'(LEAD_DLY - 1)) begin
          state_d    = FETCH;
          byte_idx_d = '0;
        end
      end
      FETCH: begin
        state_d = WAIT_DATA;
        wait_d  = '0;
      end
      WAIT_DATA: begin
        wait_d = wait_q + 2'd1;
        if (wait_q == 2'(RD_LAT - 1)) begin
          load    = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (sh_done) begin
          byte_idx_d = byte_idx_q + 8'd1;
          if (last_byte) begin
            state_d  = DIR_OFF;
            cnt_d    = '0;
            dir_tx_d = 1'b0;
          end else begin
            state_d = FETCH;
          end
        end
      end
      DIR_OFF: begin
        if (cnt_q == 16'(TAIL_DLY - 1)) begin
          dir_rx_d = 1'b0;
          full_d   = 1'b1;
          busy_d   = 1'b0;
          state_d  = HOLD;
        end
      end
      HOLD: begin
        if (!rq_s_q) begin
          state_d = IDLE;
          full_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
    if (state_d == FETCH) begin
      rd_en_d   = 1'b1;
      rd_addr_d = ADDR_W'(cycle) * ADDR_W'(NBYTES) + ADDR_W'(byte_idx_d);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      rq_meta_q  <= 1'b0;
      rq_s_q     <= 1'b0;
      cnt_q      <= '0;
      wait_q     <= '0;
      byte_idx_q <= '0;
      rd_addr_q  <= '0;
      rd_en_q    <= 1'b0;
      busy_q     <= 1'b0;
      full_q     <= 1'b0;
      dir_tx_q   <= 1'b0;
      dir_rx_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      rq_meta_q  <= rq;
      rq_s_q     <= rq_meta_q;
      cnt_q      <= cnt_d;
      wait_q     <= wait_d;
      byte_idx_q <= byte_idx_d;
      rd_addr_q  <= rd_addr_d;
      rd_en_q    <= rd_en_d;
      busy_q     <= busy_d;
      full_q     <= full_d;
      dir_tx_q   <= dir_tx_d;
      dir_rx_q   <= dir_rx_d;
    end
  end

  uart_tx_shifter #(
    .DATA_BITS   (DATA_BITS),
    .PARITY      (PARITY),
    .STOP_BITS   (STOP_BITS),
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_shifter (
    .clk  (clk),
    .reset(reset),
    .load (load),
    .data (rd_data),
    .tx   (tx),
    .done (sh_done)
  );

  assign rd_addr  = rd_addr_q;
  assign rd_en    = rd_en_q;
  assign byte_idx = byte_idx_q;
  assign busy     = busy_q;
  assign full     = full_q;
  assign dir_tx   = dir_tx_q;
  assign dir_rx   = dir_rx_q;

endmodule

// File: tb/tb_rs485_frame_tx.sv
// Bench for rs485_frame_tx: four configurations share one memory model; expected
// character bit patterns come from a vector table and are checked through a scoreboard queue.
module tb_rs485_frame_tx;

  typedef struct {
    int          inst;
    int          addr;
    logic [7:0]  data;
    int          nbits;
    logic [15:0] bits;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [3:0] rq_v = '0;
  logic [5:0] cycle_a, cycle_b, cycle_c, cycle_d;

  logic [7:0] rd_data_a, rd_data_c, rd_data_d;
  logic [6:0] rd_data_b;
  logic [8:0] rd_addr_a, rd_addr_b, rd_addr_c, rd_addr_d;
  logic       rd_en_a, rd_en_b, rd_en_c, rd_en_d;
  logic [7:0] byte_idx_a, byte_idx_b, byte_idx_c, byte_idx_d;
  logic       busy_a, busy_b, busy_c, busy_d;
  logic       full_a, full_b, full_c, full_d;
  logic       tx_a, tx_b, tx_c, tx_d;
  logic       dir_tx_a, dir_tx_b, dir_tx_c, dir_tx_d;
  logic       dir_rx_a, dir_rx_b, dir_rx_c, dir_rx_d;

  logic [7:0] mem [0:511];
  logic [8:0] addr_log_a[$];
  logic [8:0] addr_log_d[$];
  int         reads_b = 0;

  vec_t vecs [0:5];
  vec_t sb[$];
  int   sel = 0;
  logic tx_sel;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  rs485_frame_tx #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .CLKS_PER_BIT(1), .NBYTES(4)) dut_a (
    .clk(clk), .reset(reset), .rq(rq_v[0]), .cycle(cycle_a), .rd_data(rd_data_a),
    .rd_addr(rd_addr_a), .rd_en(rd_en_a), .byte_idx(byte_idx_a), .busy(busy_a),
    .full(full_a), .tx(tx_a), .dir_tx(dir_tx_a), .dir_rx(dir_rx_a));

  rs485_frame_tx #(.DATA_BITS(7), .PARITY(1), .STOP_BITS(2), .CLKS_PER_BIT(1), .NBYTES(1)) dut_b (
    .clk(clk), .reset(reset), .rq(rq_v[1]), .cycle(cycle_b), .rd_data(rd_data_b),
    .rd_addr(rd_addr_b), .rd_en(rd_en_b), .byte_idx(byte_idx_b), .busy(busy_b),
    .full(full_b), .tx(tx_b), .dir_tx(dir_tx_b), .dir_rx(dir_rx_b));

  rs485_frame_tx #(.DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .CLKS_PER_BIT(4), .NBYTES(1)) dut_c (
    .clk(clk), .reset(reset), .rq(rq_v[2]), .cycle(cycle_c), .rd_data(rd_data_c),
    .rd_addr(rd_addr_c), .rd_en(rd_en_c), .byte_idx(byte_idx_c), .busy(busy_c),
    .full(full_c), .tx(tx_c), .dir_tx(dir_tx_c), .dir_rx(dir_rx_c));

  rs485_frame_tx #(.NBYTES(16), .CYC_W(6), .ADDR_W(9)) dut_d (
    .clk(clk), .reset(reset), .rq(rq_v[3]), .cycle(cycle_d), .rd_data(rd_data_d),
    .rd_addr(rd_addr_d), .rd_en(rd_en_d), .byte_idx(byte_idx_d), .busy(busy_d),
    .full(full_d), .tx(tx_d), .dir_tx(dir_tx_d), .dir_rx(dir_rx_d));

  // Synchronous memory with one clock of read latency, shared by all instances.
  always @(posedge clk) begin
    if (rd_en_a) begin
      rd_data_a <= mem[rd_addr_a];
      addr_log_a.push_back(rd_addr_a);
    end
    if (rd_en_b) begin
      rd_data_b <= mem[rd_addr_b][6:0];
      reads_b   <= reads_b + 1;
    end
    if (rd_en_c) rd_data_c <= mem[rd_addr_c];
    if (rd_en_d) begin
      rd_data_d <= mem[rd_addr_d];
      addr_log_d.push_back(rd_addr_d);
    end
  end

  always_comb begin
    case (sel)
      0:       tx_sel = tx_a;
      1:       tx_sel = tx_b;
      2:       tx_sel = tx_c;
      default: tx_sel = tx_d;
    endcase
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input int inst, input int first, input int count);
    for (int i = first; i < first + count; i++) sb.push_back(vecs[i]);
    @(negedge clk);
    rq_v[inst] = 1'b1;
  endtask

  // Waits for a start bit, then samples every clock of every bit; gap counts idle clocks before it.
  task automatic captureChar(input int nbits, input int cpb, output logic [15:0] got,
                             output int gap, output bit stable, output bit seen);
    gap = 0;
    seen = 1'b0;
    stable = 1'b1;
    got = '0;
    for (int k = 0; k < 4000 && !seen; k++) begin
      @(negedge clk);
      if (tx_sel === 1'b0) seen = 1'b1;
      else gap++;
    end
    if (seen) begin
      for (int b = 0; b < nbits; b++) begin
        for (int c = 0; c < cpb; c++) begin
          if (!(b == 0 && c == 0)) @(negedge clk);
          if (c == 0) got[b] = tx_sel;
          else if (tx_sel !== got[b]) stable = 1'b0;
        end
      end
    end
  endtask

  task automatic runFrame(input int count, input int cpb, input string tag);
    vec_t e;
    logic [15:0] got;
    int gap;
    bit stable, seen;
    for (int j = 0; j < count; j++) begin
      checkOutput($sformatf("%s scoreboard not empty", tag), 32'(sb.size() > 0), 1);
      if (sb.size() == 0) return;
      e = sb.pop_front();
      captureChar(e.nbits, cpb, got, gap, stable, seen);
      checkOutput($sformatf("%s char%0d start seen", tag, j), 32'(seen), 1);
      if (!seen) return;
      checkOutput($sformatf("%s char%0d bits", tag, j), 32'(got), 32'(e.bits));
      checkOutput($sformatf("%s char%0d bit width", tag, j), 32'(stable), 1);
      if (j > 0) checkOutput($sformatf("%s char%0d gap", tag, j), gap, 2);
    end
  endtask

  initial begin
    int n, m, viol, base;
    bit found;

    // Bit i of .bits is the i-th bit on the line: start, data LSB first, parity, stops.
    vecs[0] = '{0, 12, 8'h55, 10, 16'h02AA};
    vecs[1] = '{0, 13, 8'hAA, 10, 16'h0354};
    vecs[2] = '{0, 14, 8'h00, 10, 16'h0200};
    vecs[3] = '{0, 15, 8'hFF, 10, 16'h03FE};
    vecs[4] = '{1, 0,  8'h07, 11, 16'h070E};
    vecs[5] = '{2, 1,  8'h03, 11, 16'h0606};
    for (int i = 0; i < 512; i++) mem[i] = 8'(i);
    for (int i = 0; i < 6; i++) mem[vecs[i].addr] = vecs[i].data;
    cycle_a = 6'd3;
    cycle_b = 6'd0;
    cycle_c = 6'd1;
    cycle_d = 6'd63;

    repeat (3) @(negedge clk);
    checkOutput("reset tx", tx_a, 1);
    checkOutput("reset dir_tx", dir_tx_a, 0);
    checkOutput("reset dir_rx", dir_rx_a, 0);
    checkOutput("reset full", full_a, 0);
    checkOutput("reset busy", busy_a, 0);
    checkOutput("reset rd_en", rd_en_a, 0);
    checkOutput("reset rd_addr", 32'(rd_addr_a), 0);
    checkOutput("reset byte_idx", 32'(byte_idx_a), 0);
    checkOutput("reset tx others", {tx_b, tx_c, tx_d}, 3'b111);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // Default 8N1 frame of four characters; rq is a 5-clock pulse.
    sel = 0;
    applyStimulus(0, 0, 4);
    n = 0;
    while (dir_rx_a !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    checkOutput("A dir_rx latency", n, 3);
    m = 0;
    while (dir_tx_a !== 1'b1 && m < 50) begin
      @(negedge clk);
      m++;
      if (n + m == 5) rq_v[0] = 1'b0;
    end
    rq_v[0] = 1'b0;
    checkOutput("A dir_tx after dir_rx", m, 15);
    runFrame(4, 1, "A");
    @(negedge clk);
    checkOutput("A dir_tx release", dir_tx_a, 0);
    n = 0;
    while (dir_rx_a !== 1'b0 && n < 50) begin @(negedge clk); n++; end
    checkOutput("A tail delay", n, 4);
    checkOutput("A full at tail", full_a, 1);
    checkOutput("A busy at tail", busy_a, 0);
    n = 0;
    while (full_a !== 1'b0 && n < 50) begin @(negedge clk); n++; end
    checkOutput("A full clear", n, 1);
    checkOutput("A read count", addr_log_a.size(), 4);
    for (int i = 0; i < 4 && i < addr_log_a.size(); i++)
      checkOutput($sformatf("A addr %0d", i), 32'(addr_log_a[i]), vecs[i].addr);

    // 7E2 with rq held high: one frame only, full held until rq drops.
    sel = 1;
    applyStimulus(1, 4, 1);
    runFrame(1, 1, "B");
    n = 0;
    while (full_b !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    checkOutput("B full reached", 32'(full_b), 1);
    viol = 0;
    repeat (150) begin
      @(negedge clk);
      if (full_b !== 1'b1 || busy_b !== 1'b0 || tx_b !== 1'b1) viol++;
    end
    checkOutput("B hold violations", viol, 0);
    checkOutput("B single read", reads_b, 1);
    rq_v[1] = 1'b0;
    n = 0;
    while (full_b !== 1'b0 && n < 50) begin @(negedge clk); n++; end
    checkOutput("B full clear after rq low", n, 3);
    applyStimulus(1, 4, 1);
    repeat (5) @(negedge clk);
    rq_v[1] = 1'b0;
    runFrame(1, 1, "B2");
    n = 0;
    while (full_b !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    checkOutput("B2 full reached", 32'(full_b), 1);
    checkOutput("B2 read count", reads_b, 2);

    // 8O1 at four clocks per bit.
    sel = 2;
    applyStimulus(2, 5, 1);
    repeat (5) @(negedge clk);
    rq_v[2] = 1'b0;
    runFrame(1, 4, "C");
    n = 0;
    while (full_c !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    checkOutput("C full reached", 32'(full_c), 1);

    // Address wrap: 63*16 = 1008 folds to 496 in a 9-bit address space.
    sel = 3;
    applyStimulus(3, 0, 0);
    repeat (5) @(negedge clk);
    rq_v[3] = 1'b0;
    n = 0;
    while (full_d !== 1'b1 && n < 2000) begin @(negedge clk); n++; end
    checkOutput("D full reached", 32'(full_d), 1);
    checkOutput("D read count", addr_log_d.size(), 16);
    for (int i = 0; i < 16 && i < addr_log_d.size(); i++)
      checkOutput($sformatf("D addr %0d", i), 32'(addr_log_d[i]), 496 + i);

    // Asynchronous reset during the third character, then a clean restart.
    sel = 0;
    applyStimulus(0, 0, 0);
    repeat (5) @(negedge clk);
    rq_v[0] = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 2000 && !found; k++) begin
      @(negedge clk);
      if (byte_idx_a == 8'd2 && tx_a === 1'b0) found = 1'b1;
    end
    checkOutput("R third char reached", 32'(found), 1);
    repeat (3) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    checkOutput("R tx idle", tx_a, 1);
    checkOutput("R dir_tx", dir_tx_a, 0);
    checkOutput("R dir_rx", dir_rx_a, 0);
    checkOutput("R full", full_a, 0);
    checkOutput("R busy", busy_a, 0);
    checkOutput("R byte_idx", 32'(byte_idx_a), 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    base = addr_log_a.size();
    applyStimulus(0, 0, 4);
    repeat (5) @(negedge clk);
    rq_v[0] = 1'b0;
    runFrame(4, 1, "R restart");
    checkOutput("R restart reads", addr_log_a.size() - base, 4);
    if (addr_log_a.size() > base)
      checkOutput("R restart first addr", 32'(addr_log_a[base]), vecs[0].addr);
    n = 0;
    while (full_a !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    checkOutput("R full reached", 32'(full_a), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
